// File: rtl/risc_pkg.sv
// Shared widths, ALU encodings and the micro-op record carried by the issue stage.
package risc_pkg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_AND   = 2'b01;
  localparam logic [1:0] OP_OR    = 2'b10;
  localparam logic [1:0] OP_SHIFT = 2'b11;

  typedef struct packed {
    logic [DATA_W-1:0] in1;
    logic [DATA_W-1:0] in2;
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              use_imm;
    logic [REG_AW-1:0] rd;
    logic [1:0]        operation;
    logic [2:0]        set_flag;
    logic              left_or_right;
    logic              is_arith;
    logic              is_two_c;
  } alu_uop_t;
endpackage

// File: rtl/operand_fwd_sel.sv
// Resolves one source operand against the EX and WB result buses; EX wins, r0 is always zero.
module operand_fwd_sel
  import risc_pkg::*;
(
  input  logic [REG_AW-1:0] idx_i,
  input  logic [DATA_W-1:0] dflt_data_i,
  input  logic              ex_valid_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic [DATA_W-1:0] ex_data_i,
  input  logic              wb_valid_i,
  input  logic [REG_AW-1:0] wb_rd_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [DATA_W-1:0] data_o
);
  always_comb begin
    data_o = dflt_data_i;
    if (idx_i == '0)                          data_o = '0;
    else if (ex_valid_i && (ex_rd_i == idx_i)) data_o = ex_data_i;
    else if (wb_valid_i && (wb_rd_i == idx_i)) data_o = wb_data_i;
  end
endmodule

// File: rtl/alu_issue_stage.sv
// Two-slot (main + skid) issue buffer in front of the ALU with operand forwarding
// at capture and continuous snooping of held operands.
module alu_issue_stage
  import risc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [DATA_W-1:0] in_imm,
  input  logic              in_use_imm,
  input  logic [REG_AW-1:0] in_rd,
  input  logic [1:0]        in_operation,
  input  logic [2:0]        in_set_flag,
  input  logic              in_left_or_right,
  input  logic              in_is_arith,
  input  logic              in_is_two_c,
  input  logic              ex_fwd_valid,
  input  logic [REG_AW-1:0] ex_fwd_rd,
  input  logic [DATA_W-1:0] ex_fwd_data,
  input  logic              wb_fwd_valid,
  input  logic [REG_AW-1:0] wb_fwd_rd,
  input  logic [DATA_W-1:0] wb_fwd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [1:0]        alu_operation,
  output logic [2:0]        alu_set_flag,
  output logic              alu_left_or_right,
  output logic              alu_is_arith,
  output logic              alu_is_two_c,
  output logic [REG_AW-1:0] out_rd
);
  // Handshake: a beat moves when valid & ready are both high on a rising edge;
  // in_ready is registered (= ~skid_valid), out_valid mirrors the main slot.
  alu_uop_t main_q, main_d, skid_q, skid_d;
  alu_uop_t cap_uop, main_snp, skid_snp;
  logic     main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic     in_ready_q, in_ready_d;
  logic     accept, xfer;
  logic [DATA_W-1:0] cap_rs_data, cap_rt_data;
  logic [DATA_W-1:0] main_rs_data, main_rt_data, skid_rs_data, skid_rt_data;

  operand_fwd_sel u_cap_rs (.idx_i(in_rs), .dflt_data_i(in_rs_data),
    .ex_valid_i(ex_fwd_valid), .ex_rd_i(ex_fwd_rd), .ex_data_i(ex_fwd_data),
    .wb_valid_i(wb_fwd_valid), .wb_rd_i(wb_fwd_rd), .wb_data_i(wb_fwd_data), .data_o(cap_rs_data));
  operand_fwd_sel u_cap_rt (.idx_i(in_rt), .dflt_data_i(in_rt_data),
    .ex_valid_i(ex_fwd_valid), .ex_rd_i(ex_fwd_rd), .ex_data_i(ex_fwd_data),
    .wb_valid_i(wb_fwd_valid), .wb_rd_i(wb_fwd_rd), .wb_data_i(wb_fwd_data), .data_o(cap_rt_data));
  operand_fwd_sel u_main_rs (.idx_i(main_q.rs), .dflt_data_i(main_q.in1),
    .ex_valid_i(ex_fwd_valid), .ex_rd_i(ex_fwd_rd), .ex_data_i(ex_fwd_data),
    .wb_valid_i(wb_fwd_valid), .wb_rd_i(wb_fwd_rd), .wb_data_i(wb_fwd_data), .data_o(main_rs_data));
  operand_fwd_sel u_main_rt (.idx_i(main_q.rt), .dflt_data_i(main_q.in2),
    .ex_valid_i(ex_fwd_valid), .ex_rd_i(ex_fwd_rd), .ex_data_i(ex_fwd_data),
    .wb_valid_i(wb_fwd_valid), .wb_rd_i(wb_fwd_rd), .wb_data_i(wb_fwd_data), .data_o(main_rt_data));
  operand_fwd_sel u_skid_rs (.idx_i(skid_q.rs), .dflt_data_i(skid_q.in1),
    .ex_valid_i(ex_fwd_valid), .ex_rd_i(ex_fwd_rd), .ex_data_i(ex_fwd_data),
    .wb_valid_i(wb_fwd_valid), .wb_rd_i(wb_fwd_rd), .wb_data_i(wb_fwd_data), .data_o(skid_rs_data));
  operand_fwd_sel u_skid_rt (.idx_i(skid_q.rt), .dflt_data_i(skid_q.in2),
    .ex_valid_i(ex_fwd_valid), .ex_rd_i(ex_fwd_rd), .ex_data_i(ex_fwd_data),
    .wb_valid_i(wb_fwd_valid), .wb_rd_i(wb_fwd_rd), .wb_data_i(wb_fwd_data), .data_o(skid_rt_data));

  assign accept = in_valid & in_ready_q;
  assign xfer   = main_valid_q & out_ready;

  always_comb begin
    cap_uop               = '0;
    cap_uop.in1           = cap_rs_data;
    cap_uop.in2           = in_use_imm ? in_imm : cap_rt_data;
    cap_uop.rs            = in_rs;
    cap_uop.rt            = in_rt;
    cap_uop.use_imm       = in_use_imm;
    cap_uop.rd            = in_rd;
    cap_uop.operation     = in_operation;
    cap_uop.set_flag      = in_set_flag;
    cap_uop.left_or_right = in_left_or_right;
    cap_uop.is_arith      = in_is_arith;
    cap_uop.is_two_c      = in_is_two_c;

    // Immediate operands are never snooped.
    main_snp     = main_q;
    main_snp.in1 = main_rs_data;
    if (!main_q.use_imm) main_snp.in2 = main_rt_data;
    skid_snp     = skid_q;
    skid_snp.in1 = skid_rs_data;
    if (!skid_q.use_imm) skid_snp.in2 = skid_rt_data;
  end

  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!main_valid_q) begin
      if (accept) begin
        main_d       = cap_uop;
        main_valid_d = 1'b1;
      end
    end else if (xfer) begin
      if (skid_valid_q) begin
        main_d       = skid_snp;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d = cap_uop;
      end else begin
        main_valid_d = 1'b0;
      end
    end else begin
      main_d = main_snp;
      if (skid_valid_q) begin
        skid_d = skid_snp;
      end else if (accept) begin
        skid_d       = cap_uop;
        skid_valid_d = 1'b1;
      end
    end
    in_ready_d = ~skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready          = in_ready_q;
  assign out_valid         = main_valid_q;
  assign alu_in1           = main_q.in1;
  assign alu_in2           = main_q.in2;
  assign alu_operation     = main_q.operation;
  assign alu_set_flag      = main_q.set_flag;
  assign alu_left_or_right = main_q.left_or_right;
  assign alu_is_arith      = main_q.is_arith;
  assign alu_is_two_c      = main_q.is_two_c;
  assign out_rd            = main_q.rd;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus random traffic against a queue model.
module tb_alu_issue_stage;
  import risc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, flush, in_valid, in_ready, in_use_imm;
  logic [REG_AW-1:0] in_rs, in_rt, in_rd;
  logic [DATA_W-1:0] in_rs_data, in_rt_data, in_imm;
  logic [1:0]        in_operation;
  logic [2:0]        in_set_flag;
  logic              in_left_or_right, in_is_arith, in_is_two_c;
  logic              ex_fwd_valid, wb_fwd_valid;
  logic [REG_AW-1:0] ex_fwd_rd, wb_fwd_rd;
  logic [DATA_W-1:0] ex_fwd_data, wb_fwd_data;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] alu_in1, alu_in2;
  logic [1:0]        alu_operation;
  logic [2:0]        alu_set_flag;
  logic              alu_left_or_right, alu_is_arith, alu_is_two_c;
  logic [REG_AW-1:0] out_rd;

  alu_issue_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_rd(in_rd),
    .in_operation(in_operation), .in_set_flag(in_set_flag),
    .in_left_or_right(in_left_or_right), .in_is_arith(in_is_arith), .in_is_two_c(in_is_two_c),
    .ex_fwd_valid(ex_fwd_valid), .ex_fwd_rd(ex_fwd_rd), .ex_fwd_data(ex_fwd_data),
    .wb_fwd_valid(wb_fwd_valid), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_operation(alu_operation),
    .alu_set_flag(alu_set_flag), .alu_left_or_right(alu_left_or_right),
    .alu_is_arith(alu_is_arith), .alu_is_two_c(alu_is_two_c), .out_rd(out_rd)
  );

  // Model: the ordered list of micro-ops currently held by the stage.
  typedef struct {
    logic [REG_AW-1:0] rs, rt, rd;
    logic              use_imm;
    logic [DATA_W-1:0] in1, in2;
    logic [1:0]        op;
    logic [2:0]        sf;
    logic              lr, ar, tc;
  } m_uop_t;

  m_uop_t held[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] resolve(input logic [REG_AW-1:0] idx,
                                               input logic [DATA_W-1:0] dflt);
    if (idx == 0) return '0;
    if (ex_fwd_valid && ex_fwd_rd == idx) return ex_fwd_data;
    if (wb_fwd_valid && wb_fwd_rd == idx) return wb_fwd_data;
    return dflt;
  endfunction

  task automatic check_outputs();
    check("out_valid", {31'b0, out_valid}, {31'b0, held.size() > 0});
    check("in_ready", {31'b0, in_ready}, {31'b0, held.size() < 2});
    if (held.size() > 0) begin
      check("alu_in1", alu_in1, held[0].in1);
      check("alu_in2", alu_in2, held[0].in2);
      check("alu_ctrl", {24'b0, alu_operation, alu_set_flag, alu_left_or_right, alu_is_arith, alu_is_two_c},
            {24'b0, held[0].op, held[0].sf, held[0].lr, held[0].ar, held[0].tc});
      check("out_rd", {27'b0, out_rd}, {27'b0, held[0].rd});
    end
  endtask

  // One clock: advance the model with the current inputs, then compare at the falling edge.
  task automatic cycle();
    m_uop_t nxt[$];
    m_uop_t u;
    bit     xfer, accept;
    nxt    = held;
    xfer   = (held.size() > 0) && out_ready;
    accept = in_valid && (held.size() < 2);
    if (rst) begin
      nxt.delete();
    end else begin
      if (xfer) void'(nxt.pop_front());
      foreach (nxt[i]) begin
        nxt[i].in1 = resolve(nxt[i].rs, nxt[i].in1);
        if (!nxt[i].use_imm) nxt[i].in2 = resolve(nxt[i].rt, nxt[i].in2);
      end
      if (flush) nxt.delete();
      else if (accept) begin
        u.rs = in_rs; u.rt = in_rt; u.rd = in_rd; u.use_imm = in_use_imm;
        u.in1 = resolve(in_rs, in_rs_data);
        u.in2 = in_use_imm ? in_imm : resolve(in_rt, in_rt_data);
        u.op = in_operation; u.sf = in_set_flag;
        u.lr = in_left_or_right; u.ar = in_is_arith; u.tc = in_is_two_c;
        nxt.push_back(u);
      end
    end
    @(posedge clk);
    held = nxt;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic set_idle();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    ex_fwd_valid = 1'b0; ex_fwd_rd = '0; ex_fwd_data = '0;
    wb_fwd_valid = 1'b0; wb_fwd_rd = '0; wb_fwd_data = '0;
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [31:0] rsd, input logic [31:0] rtd,
                       input logic [31:0] imm, input logic use_imm, input logic [4:0] rd);
    in_valid = 1'b1; in_rs = rs; in_rt = rt; in_rs_data = rsd; in_rt_data = rtd;
    in_imm = imm; in_use_imm = use_imm; in_rd = rd;
    in_operation = OP_ADD; in_set_flag = 3'd0;
    in_left_or_right = 1'b0; in_is_arith = 1'b0; in_is_two_c = 1'b0;
  endtask

  initial begin
    set_idle();
    drive(0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst = 1'b1;
    cycle();
    cycle();
    check("rst_in1", alu_in1, 32'h0);
    check("rst_in2", alu_in2, 32'h0);
    check("rst_op", {30'b0, alu_operation}, 32'h0);
    rst = 1'b0;

    // Streaming
    for (int i = 0; i < 4; i++) begin
      drive(1, 2, 32'd5, 32'd7, 0, 0, 5'(i + 1));
      cycle();
      check("stream_in1", alu_in1, 32'd5);
      check("stream_in2", alu_in2, 32'd7);
      check("stream_rd", {27'b0, out_rd}, i + 1);
      check("stream_rdy", {31'b0, in_ready}, 32'd1);
    end
    set_idle();
    cycle();

    // Backpressure
    out_ready = 1'b0;
    drive(1, 2, 32'hA1, 32'hA2, 0, 0, 5'd10); cycle();
    drive(1, 2, 32'hB1, 32'hB2, 0, 0, 5'd11); cycle();
    check("bp_full_rdy", {31'b0, in_ready}, 32'd0);
    drive(1, 2, 32'hC1, 32'hC2, 0, 0, 5'd12); cycle();
    check("bp_hold_a", {27'b0, out_rd}, 32'd10);
    out_ready = 1'b1;
    cycle();
    check("bp_then_b", {27'b0, out_rd}, 32'd11);
    cycle();
    check("bp_then_c", {27'b0, out_rd}, 32'd12);
    set_idle();
    cycle();
    check("bp_drained", {31'b0, out_valid}, 32'd0);

    // Forward priority
    drive(3, 0, 32'h99, 0, 0, 0, 5'd1);
    ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd3; ex_fwd_data = 32'h11;
    wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd3; wb_fwd_data = 32'h22;
    cycle();
    check("fwd_ex_wins", alu_in1, 32'h11);
    ex_fwd_valid = 1'b0;
    cycle();
    check("fwd_wb_only", alu_in1, 32'h22);
    drive(0, 0, 32'h99, 0, 0, 0, 5'd1);
    ex_fwd_valid = 1'b1; ex_fwd_rd = 5'd0; ex_fwd_data = 32'h55;
    cycle();
    check("fwd_r0_zero", alu_in1, 32'h0);
    set_idle();
    cycle();

    // Snoop while stalled
    out_ready = 1'b0;
    drive(1, 4, 32'h1, 32'h0, 0, 0, 5'd2); cycle();
    set_idle();
    wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd4; wb_fwd_data = 32'hDEAD;
    cycle();
    check("snoop_wb", alu_in2, 32'hDEAD);
    set_idle();
    cycle();
    check("snoop_kept", alu_in2, 32'hDEAD);
    out_ready = 1'b1; cycle();
    out_ready = 1'b0;
    drive(1, 4, 32'h1, 32'h0, 32'h10, 1, 5'd3);
    wb_fwd_valid = 1'b1; wb_fwd_rd = 5'd4; wb_fwd_data = 32'hBEEF;
    cycle();
    in_valid = 1'b0;
    cycle();
    check("imm_no_snoop", alu_in2, 32'h10);
    set_idle();
    out_ready = 1'b1; cycle();

    // Flush with both slots full, then with one slot and a live accept
    out_ready = 1'b0;
    drive(1, 2, 1, 2, 0, 0, 5'd4); cycle();
    drive(1, 2, 3, 4, 0, 0, 5'd5); cycle();
    drive(1, 2, 5, 6, 0, 0, 5'd20); flush = 1'b1; cycle();
    set_idle();
    check("flush_empty", {31'b0, out_valid}, 32'd0);
    check("flush_rdy", {31'b0, in_ready}, 32'd1);
    drive(1, 2, 1, 2, 0, 0, 5'd6); cycle();
    drive(1, 2, 7, 8, 0, 0, 5'd21); flush = 1'b1; cycle();
    set_idle();
    cycle();
    check("flush_drop", {31'b0, out_valid}, 32'd0);

    // Reset mid-stall, with flush also raised
    drive(1, 2, 32'h31, 32'h32, 0, 0, 5'd7); cycle();
    in_operation = OP_OR;
    drive(1, 2, 32'h41, 32'h42, 0, 0, 5'd8); cycle();
    set_idle(); rst = 1'b1; flush = 1'b1; cycle();
    check("rstmid_in1", alu_in1, 32'h0);
    check("rstmid_in2", alu_in2, 32'h0);
    check("rstmid_op", {30'b0, alu_operation}, 32'h0);
    set_idle();

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_rs = 5'($urandom_range(0, 7)); in_rt = 5'($urandom_range(0, 7));
      in_rd = 5'($urandom_range(0, 31));
      in_rs_data = $urandom; in_rt_data = $urandom; in_imm = $urandom;
      in_use_imm = 1'($urandom_range(0, 1));
      in_operation = 2'($urandom_range(0, 3)); in_set_flag = 3'($urandom_range(0, 7));
      in_left_or_right = 1'($urandom_range(0, 1));
      in_is_arith = 1'($urandom_range(0, 1)); in_is_two_c = 1'($urandom_range(0, 1));
      ex_fwd_valid = 1'($urandom_range(0, 1)); ex_fwd_rd = 5'($urandom_range(0, 7));
      ex_fwd_data = $urandom;
      wb_fwd_valid = 1'($urandom_range(0, 1)); wb_fwd_rd = 5'($urandom_range(0, 7));
      wb_fwd_data = $urandom;
      out_ready = ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 49) == 0);
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
